elevator_car_controller: RTL and testbench

//  Consumer end of the elevator request path: latches floor-call pulses from the

---
 rtl/elevator_pkg.sv | 34 +++
 rtl/elevator_car_controller_timer.sv | 30 +++
 rtl/elevator_car_controller.sv | 134 +++++++++++++
 tb/tb_elevator_car_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the elevator car controller.
// Masks are zero-extended to MAX_FLOORS bits before calling the helpers.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MOVING_UP   = 2'd1,
    MOVING_DOWN = 2'd2,
    DOOR_OPEN   = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MAX_FLOORS = 32;
  typedef logic [MAX_FLOORS-1:0] fmask_t;

  function automatic logic any_above(fmask_t mask, int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i > floor && mask[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(fmask_t mask, int floor);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i < floor && mask[i]) r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/elevator_car_controller_timer.sv
// Loadable down-counter shared by travel and door timing.
// Holds at zero; done_o is high while the count is zero.
module countdown_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// SCAN-policy elevator car controller: request latch, direction FSM,
// floor counter and Moore motor/door outputs.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    piso_actual,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pendientes
);

  localparam int TMAX =
    (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] D_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    piso_q, piso_d, nf;
  logic [NUM_FLOORS-1:0] pend_q, pend_d, eff, served;
  logic                  load, t_done, up_ok, dn_ok, ahead;
  logic [TW-1:0]         load_val;

  countdown_timer #(.W(TW)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_value_i (load_val),
    .done_o       (t_done)
  );

  // Requests arriving this cycle take part in every decision.
  assign eff   = pend_q | req;
  assign up_ok = any_above(fmask_t'(eff), int'(piso_q));
  assign dn_ok = any_below(fmask_t'(eff), int'(piso_q));

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    piso_d   = piso_q;
    nf       = piso_q;
    ahead    = 1'b0;
    served   = '0;
    load     = 1'b0;
    load_val = T_LOAD;
    unique case (state_q)
      IDLE: begin
        if (eff[piso_q]) begin
          state_d  = DOOR_OPEN;
          served   = ONE << piso_q;
          load     = 1'b1;
          load_val = D_LOAD;
        end else if (up_ok && (dir_q == DIR_UP || !dn_ok)) begin
          state_d = MOVING_UP;
          dir_d   = DIR_UP;
          load    = 1'b1;
        end else if (dn_ok) begin
          state_d = MOVING_DOWN;
          dir_d   = DIR_DOWN;
          load    = 1'b1;
        end
      end
      MOVING_UP, MOVING_DOWN: begin
        if (t_done) begin
          if (state_q == MOVING_UP) begin
            nf    = piso_q + FLOOR_W'(1);
            ahead = any_above(fmask_t'(eff), int'(nf));
          end else begin
            nf    = piso_q - FLOOR_W'(1);
            ahead = any_below(fmask_t'(eff), int'(nf));
          end
          piso_d = nf;
          if (eff[nf]) begin
            state_d  = DOOR_OPEN;
            served   = ONE << nf;
            load     = 1'b1;
            load_val = D_LOAD;
          end else if (ahead) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        // A call for this floor keeps the door open rather than latching.
        served = ONE << piso_q;
        if (req[piso_q]) begin
          load     = 1'b1;
          load_val = D_LOAD;
        end else if (t_done) begin
          state_d = IDLE;
        end
      end
    endcase
    pend_d = eff & ~served;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      piso_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      piso_q  <= piso_d;
      pend_q  <= pend_d;
    end
  end

  assign piso_actual = piso_q;
  assign motor_up    = (state_q == MOVING_UP);
  assign motor_down  = (state_q == MOVING_DOWN);
  assign door_open   = (state_q == DOOR_OPEN);
  assign pendientes  = pend_q;

  a_floor_bounds: assert property (@(posedge clk) disable iff (rst)
    !((state_q == MOVING_UP && int'(piso_q) >= NUM_FLOORS - 1) ||
      (state_q == MOVING_DOWN && piso_q == '0)));

endmodule

// File: tb/tb_elevator_car_controller.sv
// Vector-table bench for elevator_car_controller with 4 floors,
// travel 4 cycles and door 3 cycles.
module tb_elevator_car_controller;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] piso;
    logic       up;
    logic       dn;
    logic       door;
    logic [3:0] pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'h0;
  logic [1:0] piso_actual;
  logic       motor_up, motor_down, door_open;
  logic [3:0] pendientes;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  elevator_car_controller #(
    .NUM_FLOORS    (4),
    .FLOOR_W       (2),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .piso_actual (piso_actual),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .door_open   (door_open),
    .pendientes  (pendientes)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks done", total_cnt);
    $fatal(1);
  end

  task automatic add(int n, int r, int q, int p,
                     int u, int d, int o, int m);
    vec_t v;
    v.rst  = 1'(r);
    v.req  = 4'(q);
    v.piso = 2'(p);
    v.up   = 1'(u);
    v.dn   = 1'(d);
    v.door = 1'(o);
    v.pend = 4'(m);
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(string name);
    vec_t e;
    logic [8:0] got, want;
    e = exp_q.pop_front();
    got  = {piso_actual, motor_up, motor_down, door_open, pendientes};
    want = {e.piso, e.up, e.dn, e.door, e.pend};
    total_cnt++;
    if (got !== want)
      $display("FAIL %s: got piso/up/dn/door/pend=%b want %b",
               name, got, want);
    else
      pass_cnt++;
  endtask

  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    rst = v.rst;
    req = v.req;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check($sformatf("row%0d", idx));
  endtask

  initial begin
    vec_t z;
    // reset
    add(2, 1, 'h0, 0, 0, 0, 0, 'h0);
    // same-floor call: door 3 cycles, nothing latched
    add(1, 0, 'h1, 0, 0, 0, 1, 'h0);
    add(2, 0, 'h0, 0, 0, 0, 1, 'h0);
    add(1, 0, 'h0, 0, 0, 0, 0, 'h0);
    // call to top floor: 12 cycles up, then door
    add(1, 0, 'h8, 0, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 0, 1, 0, 0, 'h8);
    add(4, 0, 'h0, 1, 1, 0, 0, 'h8);
    add(4, 0, 'h0, 2, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 3, 0, 0, 1, 'h0);
    add(1, 0, 'h0, 3, 0, 0, 0, 'h0);
    // all calls at once at floor 0
    add(1, 1, 'h0, 0, 0, 0, 0, 'h0);
    add(1, 0, 'hF, 0, 0, 0, 1, 'hE);
    add(1, 0, 'h0, 0, 0, 0, 1, 'hE);
    add(1, 1, 'h0, 0, 0, 0, 0, 'h0);
    // going to 3, floor 2 called between 1 and 2
    add(1, 0, 'h8, 0, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 0, 1, 0, 0, 'h8);
    add(1, 0, 'h0, 1, 1, 0, 0, 'h8);
    add(1, 0, 'h4, 1, 1, 0, 0, 'hC);
    add(2, 0, 'h0, 1, 1, 0, 0, 'hC);
    add(3, 0, 'h0, 2, 0, 0, 1, 'h8);
    add(1, 0, 'h0, 2, 0, 0, 0, 'h8);
    add(4, 0, 'h0, 2, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 3, 0, 0, 1, 'h0);
    add(1, 0, 'h0, 3, 0, 0, 0, 'h0);
    add(1, 1, 'h0, 0, 0, 0, 0, 'h0);
    // call behind the car: serve 3 first, then reverse to 0
    add(1, 0, 'h8, 0, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 0, 1, 0, 0, 'h8);
    add(4, 0, 'h0, 1, 1, 0, 0, 'h8);
    add(1, 0, 'h1, 2, 1, 0, 0, 'h9);
    add(3, 0, 'h0, 2, 1, 0, 0, 'h9);
    add(3, 0, 'h0, 3, 0, 0, 1, 'h1);
    add(1, 0, 'h0, 3, 0, 0, 0, 'h1);
    add(4, 0, 'h0, 3, 0, 1, 0, 'h1);
    add(4, 0, 'h0, 2, 0, 1, 0, 'h1);
    add(4, 0, 'h0, 1, 0, 1, 0, 'h1);
    add(3, 0, 'h0, 0, 0, 0, 1, 'h0);
    add(1, 0, 'h0, 0, 0, 0, 0, 'h0);
    add(1, 1, 'h0, 0, 0, 0, 0, 'h0);
    // door at floor 1 reopened by a call at timer zero
    add(1, 0, 'h2, 0, 1, 0, 0, 'h2);
    add(3, 0, 'h0, 0, 1, 0, 0, 'h2);
    add(3, 0, 'h0, 1, 0, 0, 1, 'h0);
    add(1, 0, 'h2, 1, 0, 0, 1, 'h0);
    add(2, 0, 'h0, 1, 0, 0, 1, 'h0);
    add(1, 0, 'h0, 1, 0, 0, 0, 'h0);
    add(1, 1, 'h0, 0, 0, 0, 0, 'h0);
    // lead-up to reset while moving up at floor 2
    add(1, 0, 'h8, 0, 1, 0, 0, 'h8);
    add(3, 0, 'h0, 0, 1, 0, 0, 'h8);
    add(4, 0, 'h0, 1, 1, 0, 0, 'h8);
    add(1, 0, 'h0, 2, 1, 0, 0, 'h8);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    z = '{rst: 1'b1, req: 4'h0, piso: 2'd0, up: 1'b0,
          dn: 1'b0, door: 1'b0, pend: 4'h0};
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.push_back(z);
    check("async_reset_same_edge");
    @(posedge clk);
    #1;
    exp_q.push_back(z);
    check("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(z);
    check("after_reset_no_motor");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
